// File: rtl/frame_builder_pkg.sv
// Shared definitions for the UART response frame builder: SOF marker, status codes,
// builder state encoding and the CRC8 step used by both builder and Frame Parser.
package frame_builder_pkg;

  localparam logic [7:0] RESP_SOF = 8'h5A;

  localparam logic [7:0] STATUS_OK       = 8'h00;
  localparam logic [7:0] STATUS_CRC_ERR  = 8'h01;
  localparam logic [7:0] STATUS_BAD_CMD  = 8'h02;
  localparam logic [7:0] STATUS_BUS_ERR  = 8'h03;
  localparam logic [7:0] STATUS_TIMEOUT  = 8'h04;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_STATUS,
    ST_CMD,
`ifdef RESP_ADDR_ECHO_EN
    ST_ADDR0,
    ST_ADDR1,
    ST_ADDR2,
    ST_ADDR3,
`endif
    ST_DATA,
    ST_CRC,
    ST_DONE
  } build_state_t;

  // CRC8, poly 0x07, MSB-first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_builder_crc8.sv
// Running CRC8 accumulator: clear restarts at 0x00, enable folds one byte per cycle.
module crc8_calc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] byte_in,
  output logic [7:0] crc
);
  import frame_builder_pkg::*;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc8_update(crc, byte_in);
    end
  end

endmodule

// File: rtl/frame_builder.sv
// UART response frame builder: SOF, STATUS, CMD, [ADDR echo], [DATA], CRC8 into the TX FIFO.
// Address echo on read OK responses is enabled by defining RESP_ADDR_ECHO_EN.
module frame_builder #(
  parameter int unsigned MAX_DATA_BYTES = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        build_valid,
  output logic        build_ready,
  input  logic [7:0]  status,
  input  logic [7:0]  cmd,
  input  logic [31:0] addr,
  input  logic [5:0]  data_count,
  output logic [5:0]  data_idx,
  input  logic [7:0]  data_byte,
  input  logic        tx_fifo_full,
  output logic        tx_fifo_wr_en,
  output logic [7:0]  tx_fifo_data,
  output logic        busy,
  output logic        frame_done
);
  import frame_builder_pkg::*;

  build_state_t state;
  build_state_t after_cmd;
  logic [7:0]   status_q;
  logic [7:0]   cmd_q;
  logic [5:0]   count_q;
  logic [5:0]   count_clamped;
  logic [7:0]   crc;
  logic [7:0]   byte_mux;
  logic         emit;
  logic         crc_cover;
  logic         write;
  logic         accept;
  logic         rd_ok;

`ifdef RESP_ADDR_ECHO_EN
  logic [31:0]  addr_q;
`else
  logic         addr_unused;
  assign addr_unused = ^addr;
`endif

  assign build_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign frame_done  = (state == ST_DONE);
  assign accept      = build_valid && build_ready;
  assign rd_ok       = cmd_q[7] && (status_q == STATUS_OK);
  assign after_cmd   = (rd_ok && (count_q != '0)) ? ST_DATA : ST_CRC;

  assign count_clamped = (32'(data_count) > MAX_DATA_BYTES) ? 6'(MAX_DATA_BYTES) : data_count;

  // Write strobe and byte are decoded from the registered state so a FIFO-full
  // or the same-cycle data_byte lookup takes effect without a cycle of slip.
  always_comb begin
    byte_mux  = '0;
    emit      = 1'b0;
    crc_cover = 1'b0;
    case (state)
      ST_SOF:    begin byte_mux = RESP_SOF;  emit = 1'b1; end
      ST_STATUS: begin byte_mux = status_q;  emit = 1'b1; crc_cover = 1'b1; end
      ST_CMD:    begin byte_mux = cmd_q;     emit = 1'b1; crc_cover = 1'b1; end
`ifdef RESP_ADDR_ECHO_EN
      ST_ADDR0:  begin byte_mux = addr_q[7:0];   emit = 1'b1; crc_cover = 1'b1; end
      ST_ADDR1:  begin byte_mux = addr_q[15:8];  emit = 1'b1; crc_cover = 1'b1; end
      ST_ADDR2:  begin byte_mux = addr_q[23:16]; emit = 1'b1; crc_cover = 1'b1; end
      ST_ADDR3:  begin byte_mux = addr_q[31:24]; emit = 1'b1; crc_cover = 1'b1; end
`endif
      ST_DATA:   begin byte_mux = data_byte; emit = 1'b1; crc_cover = 1'b1; end
      ST_CRC:    begin byte_mux = crc;       emit = 1'b1; end
      default:   ;
    endcase
  end

  assign write         = emit && !tx_fifo_full && !rst;
  assign tx_fifo_wr_en = write;
  assign tx_fifo_data  = write ? byte_mux : '0;

  crc8_calc u_crc (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (write && crc_cover),
    .byte_in (byte_mux),
    .crc     (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      status_q <= '0;
      cmd_q    <= '0;
      count_q  <= '0;
      data_idx <= '0;
`ifdef RESP_ADDR_ECHO_EN
      addr_q   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (build_valid) begin
          status_q <= status;
          cmd_q    <= cmd;
          count_q  <= count_clamped;
          data_idx <= '0;
`ifdef RESP_ADDR_ECHO_EN
          addr_q   <= addr;
`endif
          state    <= ST_SOF;
        end
        ST_SOF:    if (write) state <= ST_STATUS;
        ST_STATUS: if (write) state <= ST_CMD;
`ifdef RESP_ADDR_ECHO_EN
        ST_CMD:    if (write) state <= rd_ok ? ST_ADDR0 : after_cmd;
        ST_ADDR0:  if (write) state <= ST_ADDR1;
        ST_ADDR1:  if (write) state <= ST_ADDR2;
        ST_ADDR2:  if (write) state <= ST_ADDR3;
        ST_ADDR3:  if (write) state <= after_cmd;
`else
        ST_CMD:    if (write) state <= after_cmd;
`endif
        ST_DATA: if (write) begin
          if (data_idx == count_q - 6'd1) state <= ST_CRC;
          else                            data_idx <= data_idx + 6'd1;
        end
        ST_CRC:  if (write) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
